spi_shift_ctrl: RTL and testbench
=================================

SPI_SHIFT_CTRL -- requirements
Module: spi_shift_ctrl

Interface
REQ-001 The block SHALL have parameter AMP_BITS, default 8, giving the number of edges in an amplifier gain frame.
REQ-002 The block SHALL have parameter ADC_BITS, default 34, giving the number of edges in an ADC sample frame.
REQ-003 Port clk: input, 1 bit, the single system clock; all logic is clocked on its rising edge.
REQ-004 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-005 Port SPI_CLK: input, 1 bit, one-cycle edge request from the flank FSM.
REQ-006 Port Reg_Rst: input, 1 bit, one-cycle frame clear from the flank FSM.
REQ-007 Port AMP_ADC: input, 1 bit; 0 selects an amplifier frame, 1 selects an ADC frame.
REQ-008 Port Gain: input, 8 bits, gain word to transmit in amplifier frames.
REQ-009 Port MISO: input, 1 bit, serial data from the ADC.
REQ-010 Port EdgDone: output, 1 bit, frame edge count reached (returned to the flank FSM).
REQ-011 Port SCK: output, 1 bit, serial clock pin.
REQ-012 Port MOSI: output, 1 bit, serial data to the amplifier.
REQ-013 Port ChA: output, 14 bits, last captured channel A sample.
REQ-014 Port ChB: output, 14 bits, last captured channel B sample.
REQ-015 Port Data_Valid: output, 1 bit, one-cycle pulse when ChA/ChB update.

Function
REQ-016 Mode register SHALL latch AMP_ADC on every clk edge where cnt==0; limit = AMP_BITS if mode==0, else ADC_BITS.
REQ-017 Edge counter cnt (6 bits) SHALL increment on each edge with SPI_CLK=1 while cnt<limit, and saturate at limit.
REQ-018 EdgDone SHALL be combinational: EdgDone = (cnt==limit), so that it is valid in the cycle after the SPI_CLK pulse.
REQ-019 SCK SHALL be a register loaded with SPI_CLK each cycle, so SCK is high exactly one cycle after each SPI_CLK pulse.
REQ-020 tx_sr (8 bits) SHALL load Gain on every edge with cnt==0 and SPI_CLK=0; MOSI = tx_sr[7].
REQ-021 On each edge with SCK=1 (SCK falling), tx_sr SHALL shift left with 0 fill; MOSI is therefore stable across each SCK high phase.
REQ-022 On each edge with SCK=1 and mode==1, rx_sr (34 bits) SHALL shift left with MISO into bit 0.
REQ-023 On an edge with Reg_Rst=1, mode==1 and cnt==ADC_BITS: ChA <= rx_sr[31:18], ChB <= rx_sr[15:2], and Data_Valid=1 for the next cycle only.
REQ-024 rx_sr bits 33:32, 17:16 and 1:0 are idle bits and SHALL be discarded.
REQ-025 Reg_Rst SHALL clear cnt, rx_sr and SCK, with priority over SPI_CLK when both are asserted on the same edge.
REQ-026 Amplifier frames SHALL NOT alter ChA, ChB or Data_Valid.
REQ-027 A Reg_Rst with cnt<limit (aborted frame) SHALL clear the frame without updating ChA/ChB and without pulsing Data_Valid.
REQ-028 An SPI_CLK pulse at cnt==limit SHALL still drive SCK but SHALL NOT change cnt or EdgDone.

Reset
REQ-029 rst SHALL asynchronously force cnt=0, mode=0, SCK=0, tx_sr=0, rx_sr=0, ChA=0, ChB=0 and Data_Valid=0; MOSI=0 and EdgDone=0 follow.
REQ-030 After rst deasserts, tx_sr SHALL load Gain on the first clk edge.
REQ-031 rst asserted mid-frame SHALL abort the frame with no Data_Valid pulse.

Verification
REQ-032 Test: AMP_ADC=0, Gain=8'hA5, 8x(SPI_CLK pulse, idle cycle) -> MOSI during the SCK highs is 1,0,1,0,0,1,0,1; EdgDone=1 after the 8th pulse; Data_Valid stays 0.
REQ-033 Test: AMP_ADC=1, 34 edges with MISO = 2 idle bits, 14'h2AAA, 2 idle bits, 14'h1555, 2 idle bits, then Reg_Rst -> ChA=14'h2AAA, ChB=14'h1555, and a single Data_Valid pulse.
REQ-034 Test: ADC frame aborted by Reg_Rst after 20 edges -> cnt=0, EdgDone=0, ChA/ChB unchanged, no Data_Valid.
REQ-035 Test: rst asserted after 10 ADC edges -> all outputs 0 immediately without waiting for a clk edge; a subsequent full frame captures correctly.
REQ-036 Test: SPI_CLK and Reg_Rst asserted on the same edge -> cnt=0 and SCK=0 on the next cycle.
REQ-037 Test: extra SPI_CLK pulses after EdgDone in an amplifier frame -> cnt remains 8 and MOSI remains 0.

Source files
------------

// File: rtl/spi_shift_ctrl.sv
// SPI shift controller: edge counter, serial clock, gain transmit shifter
// and ADC receive shifter with channel A/B capture.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   SPI_CLK          one-cycle edge request from the flank FSM
//   Reg_Rst          one-cycle frame clear from the flank FSM
//   AMP_ADC          frame select: 0 amplifier gain frame, 1 ADC frame
//   Gain[7:0]        gain word sent MSB first in amplifier frames
//   MISO             serial data from the ADC
//   EdgDone          frame edge count reached (combinational)
//   SCK              serial clock pin, high one cycle after each SPI_CLK
//   MOSI             serial data to the amplifier
//   ChA[13:0]        last captured channel A sample
//   ChB[13:0]        last captured channel B sample
//   Data_Valid       one-cycle pulse when ChA/ChB update

module spi_shift_ctrl #(
    parameter int AMP_BITS = 8,
    parameter int ADC_BITS = 34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SPI_CLK,
    input  logic        Reg_Rst,
    input  logic        AMP_ADC,
    input  logic [7:0]  Gain,
    input  logic        MISO,
    output logic        EdgDone,
    output logic        SCK,
    output logic        MOSI,
    output logic [13:0] ChA,
    output logic [13:0] ChB,
    output logic        Data_Valid
);

    localparam logic [5:0] AMP_LIM = 6'(AMP_BITS);
    localparam logic [5:0] ADC_LIM = 6'(ADC_BITS);

    logic        mode_q, mode_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sck_q, sck_d;
    logic [7:0]  tx_q, tx_d;
    logic [33:0] rx_q, rx_d;
    logic [13:0] cha_q, cha_d;
    logic [13:0] chb_q, chb_d;
    logic        dv_q, dv_d;

    logic [5:0]  limit;
    logic        frame_idle;
    logic        at_limit;
    logic        adc_full;

    assign limit      = mode_q ? ADC_LIM : AMP_LIM;
    assign frame_idle = (cnt_q == 6'd0);
    assign at_limit   = (cnt_q == limit);
    // A capture is only meaningful once every ADC edge has been taken.
    assign adc_full   = mode_q && (cnt_q == ADC_LIM);

    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        sck_d  = 1'b0;
        tx_d   = tx_q;
        rx_d   = rx_q;
        cha_d  = cha_q;
        chb_d  = chb_q;
        dv_d   = 1'b0;

        // Frame type is only sampled between frames so it cannot
        // change the edge limit while a frame is in progress.
        if (frame_idle) begin
            mode_d = AMP_ADC;
        end

        // Frame clear wins over an edge request on the same cycle.
        if (Reg_Rst) begin
            cnt_d = 6'd0;
        end else if (SPI_CLK && !at_limit && (cnt_q < limit)) begin
            cnt_d = cnt_q + 6'd1;
        end

        sck_d = SPI_CLK && !Reg_Rst;

        // Shifting on the cycle SCK is high moves the next bit out at
        // SCK fall, keeping MOSI stable over the whole high phase.
        if (frame_idle && !SPI_CLK) begin
            tx_d = Gain;
        end else if (sck_q) begin
            tx_d = tx_q << 1;
        end

        if (Reg_Rst) begin
            rx_d = '0;
        end else if (sck_q && mode_q) begin
            rx_d = (rx_q << 1) | {33'd0, MISO};
        end

        // Idle bits 33:32, 17:16 and 1:0 are dropped here.
        if (Reg_Rst && adc_full) begin
            cha_d = rx_q[31:18];
            chb_d = rx_q[15:2];
            dv_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
            cnt_q  <= 6'd0;
            sck_q  <= 1'b0;
            tx_q   <= 8'd0;
            rx_q   <= '0;
            cha_q  <= 14'd0;
            chb_q  <= 14'd0;
            dv_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            sck_q  <= sck_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            cha_q  <= cha_d;
            chb_q  <= chb_d;
            dv_q   <= dv_d;
        end
    end

    assign EdgDone    = at_limit;
    assign SCK        = sck_q;
    assign MOSI       = tx_q[7];
    assign ChA        = cha_q;
    assign ChB        = chb_q;
    assign Data_Valid = dv_q;

endmodule

// File: tb/tb_spi_shift_ctrl.sv
// Bench for spi_shift_ctrl: frame vector table, corner-case sequences
// and random frames checked against a frame-level reference model.

module tb_spi_shift_ctrl;

    logic        clk;
    logic        rst;
    logic        SPI_CLK;
    logic        Reg_Rst;
    logic        AMP_ADC;
    logic [7:0]  Gain;
    logic        MISO;
    logic        EdgDone;
    logic        SCK;
    logic        MOSI;
    logic [13:0] ChA;
    logic [13:0] ChB;
    logic        Data_Valid;

    spi_shift_ctrl #(.AMP_BITS(8), .ADC_BITS(34)) dut (
        .clk        (clk),
        .rst        (rst),
        .SPI_CLK    (SPI_CLK),
        .Reg_Rst    (Reg_Rst),
        .AMP_ADC    (AMP_ADC),
        .Gain       (Gain),
        .MISO       (MISO),
        .EdgDone    (EdgDone),
        .SCK        (SCK),
        .MOSI       (MOSI),
        .ChA        (ChA),
        .ChB        (ChB),
        .Data_Valid (Data_Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int dv_cnt = 0;

    always @(negedge clk) begin
        if (Data_Valid === 1'b1) dv_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        is_adc;
        logic [7:0]  gain;
        logic [1:0]  i0, i1, i2;
        logic [13:0] a, b;
        int          edges;
        logic [7:0]  exp_mosi;
        logic        exp_done;
        int          exp_dv;
        logic [13:0] exp_cha, exp_chb;
    } vec_t;

    vec_t vecs[6];

    // One pulse+idle per edge, then Reg_Rst. Returns the MOSI bits seen
    // during SCK highs, EdgDone before the clear, and Data_Valid pulses.
    task automatic run_frame(input logic adc, input logic [7:0] g,
                             input logic [33:0] w, input int edges,
                             output logic [7:0] seen, output logic done_b,
                             output int dvp, output logic sck_ok);
        int dv0;
        seen = 8'd0;
        sck_ok = 1'b1;
        AMP_ADC = adc;
        Gain = g;
        SPI_CLK = 1'b0;
        Reg_Rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        dv0 = dv_cnt;
        for (int i = 0; i < edges; i++) begin
            MISO = w[33-i];
            SPI_CLK = 1'b1;
            @(posedge clk);
            #1;
            SPI_CLK = 1'b0;
            seen = {seen[6:0], MOSI};
            if (SCK !== 1'b1) sck_ok = 1'b0;
            @(posedge clk);
            #1;
            if (SCK !== 1'b0) sck_ok = 1'b0;
        end
        done_b = EdgDone;
        Reg_Rst = 1'b1;
        @(posedge clk);
        #1;
        Reg_Rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        dvp = dv_cnt - dv0;
    endtask

    logic [13:0] cha_m, chb_m;
    logic [7:0]  seen;
    logic        done_b, sck_ok, ok;
    int          dvp;
    logic [33:0] w;
    logic [63:0] r64;

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 2'd0, 2'd0, 2'd0, 14'h0, 14'h0, 8,
                    8'hA5, 1'b1, 0, 14'h0000, 14'h0000};
        vecs[1] = '{1'b1, 8'h00, 2'd0, 2'd0, 2'd0, 14'h2AAA, 14'h1555, 34,
                    8'h00, 1'b1, 1, 14'h2AAA, 14'h1555};
        vecs[2] = '{1'b1, 8'h00, 2'd3, 2'd3, 2'd3, 14'h3FFF, 14'h3FFF, 20,
                    8'h00, 1'b0, 0, 14'h2AAA, 14'h1555};
        vecs[3] = '{1'b0, 8'h3C, 2'd0, 2'd0, 2'd0, 14'h0, 14'h0, 8,
                    8'h3C, 1'b1, 0, 14'h2AAA, 14'h1555};
        vecs[4] = '{1'b1, 8'h00, 2'd3, 2'd2, 2'd1, 14'h1234, 14'h0F0F, 34,
                    8'h00, 1'b1, 1, 14'h1234, 14'h0F0F};
        vecs[5] = '{1'b0, 8'h81, 2'd0, 2'd0, 2'd0, 14'h0, 14'h0, 5,
                    8'h10, 1'b0, 0, 14'h1234, 14'h0F0F};

        rst = 1'b1;
        SPI_CLK = 1'b0;
        Reg_Rst = 1'b0;
        AMP_ADC = 1'b0;
        Gain = 8'h80;
        MISO = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {EdgDone, SCK, MOSI, Data_Valid, ChA, ChB}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("gain_load_after_rst", MOSI, 1'b1);

        // frame vector table
        for (int v = 0; v < 6; v++) begin
            w = {vecs[v].i0, vecs[v].a, vecs[v].i1, vecs[v].b, vecs[v].i2};
            run_frame(vecs[v].is_adc, vecs[v].gain, w, vecs[v].edges,
                      seen, done_b, dvp, sck_ok);
            if (!vecs[v].is_adc)
                chk($sformatf("vec%0d_mosi", v), seen, vecs[v].exp_mosi);
            chk($sformatf("vec%0d_sck", v), sck_ok, 1'b1);
            chk($sformatf("vec%0d_done", v), done_b, vecs[v].exp_done);
            chk($sformatf("vec%0d_done_clr", v), EdgDone, 1'b0);
            chk($sformatf("vec%0d_dv", v), dvp, vecs[v].exp_dv);
            chk($sformatf("vec%0d_cha", v), ChA, vecs[v].exp_cha);
            chk($sformatf("vec%0d_chb", v), ChB, vecs[v].exp_chb);
        end
        cha_m = 14'h1234;
        chb_m = 14'h0F0F;

        // SPI_CLK and Reg_Rst on the same edge
        AMP_ADC = 1'b0;
        Gain = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            SPI_CLK = 1'b1;
            @(posedge clk);
            #1;
            SPI_CLK = 1'b0;
            @(posedge clk);
            #1;
        end
        SPI_CLK = 1'b1;
        Reg_Rst = 1'b1;
        @(posedge clk);
        #1;
        SPI_CLK = 1'b0;
        Reg_Rst = 1'b0;
        chk("both_sck", SCK, 1'b0);
        chk("both_done", EdgDone, 1'b0);
        dvp = 0;
        for (int i = 0; i < 12 && EdgDone !== 1'b1; i++) begin
            SPI_CLK = 1'b1;
            @(posedge clk);
            #1;
            SPI_CLK = 1'b0;
            dvp++;
            @(posedge clk);
            #1;
        end
        chk("both_edges_to_done", dvp, 8);
        Reg_Rst = 1'b1;
        @(posedge clk);
        #1;
        Reg_Rst = 1'b0;

        // extra pulses after EdgDone in an amplifier frame
        Gain = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            SPI_CLK = 1'b1;
            @(posedge clk);
            #1;
            SPI_CLK = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("extra_done_pre", EdgDone, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            SPI_CLK = 1'b1;
            @(posedge clk);
            #1;
            SPI_CLK = 1'b0;
            if (SCK !== 1'b1 || MOSI !== 1'b0 || EdgDone !== 1'b1) ok = 1'b0;
            @(posedge clk);
            #1;
            if (MOSI !== 1'b0 || EdgDone !== 1'b1) ok = 1'b0;
        end
        chk("extra_pulses", ok, 1'b1);
        chk("extra_cnt", dut.cnt_q, 6'd8);
        Reg_Rst = 1'b1;
        @(posedge clk);
        #1;
        Reg_Rst = 1'b0;

        // asynchronous reset mid ADC frame
        AMP_ADC = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        dvp = dv_cnt;
        for (int i = 0; i < 10; i++) begin
            MISO = 1'b1;
            SPI_CLK = 1'b1;
            @(posedge clk);
            #1;
            SPI_CLK = 1'b0;
            if (i < 9) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outs", {EdgDone, SCK, MOSI, Data_Valid, ChA, ChB},
            64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("async_rst_no_dv", dv_cnt - dvp, 0);
        cha_m = 14'd0;
        chb_m = 14'd0;
        w = {2'b01, 14'h0ACE, 2'b10, 14'h3210, 2'b11};
        run_frame(1'b1, 8'h00, w, 34, seen, done_b, dvp, sck_ok);
        chk("post_rst_cha", ChA, 14'h0ACE);
        chk("post_rst_chb", ChB, 14'h3210);
        chk("post_rst_dv", dvp, 1);
        cha_m = 14'h0ACE;
        chb_m = 14'h3210;

        // random frames against the frame-level model
        for (int f = 0; f < 24; f++) begin
            int kind;
            int edges;
            logic [7:0] g;
            kind = $urandom_range(0, 2);
            g = 8'($urandom);
            r64 = {$urandom, $urandom};
            w = r64[33:0];
            edges = (kind == 0) ? 8 :
                    (kind == 1) ? 34 : $urandom_range(1, 33);
            run_frame(kind != 0, g, w, edges, seen, done_b, dvp, sck_ok);
            if (kind == 0) chk($sformatf("rnd%0d_mosi", f), seen, g);
            if (kind == 1) begin
                cha_m = w[31:18];
                chb_m = w[15:2];
            end
            chk($sformatf("rnd%0d_done", f), done_b, kind != 2);
            chk($sformatf("rnd%0d_dv", f), dvp, (kind == 1) ? 1 : 0);
            chk($sformatf("rnd%0d_ch", f), {ChA, ChB}, {cha_m, chb_m});
            chk($sformatf("rnd%0d_sck", f), sck_ok, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
